// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one-cycle pipeline register stage with optional two-entry skid buffer, flush and stall counter
module pipe_stage #(
  parameter int               WIDTH       = 64,
  parameter int               SKID        = 1,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_cnt
);

  // EMPTY: nothing held; FULL: main holds the head; SKIDF: main and skid both held
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKIDF = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q, valid_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire;
  logic             out_fire;

  // With the skid buffer the ready is a flop; without it, ready looks through to out_ready
  assign in_ready  = (SKID != 0) ? rdy_q : (!valid_q || out_ready);
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  // Next-state and payload movement; main is reloaded with FLUSH_VALUE whenever it empties
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end else if (SKID != 0) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_SKIDF;
          end else if (out_fire) begin
            main_d  = FLUSH_VALUE;
            state_d = ST_EMPTY;
          end
        end
        ST_SKIDF: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = FLUSH_VALUE;
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = FLUSH_VALUE;
          skid_d  = FLUSH_VALUE;
        end
      endcase
    end else begin
      if (in_fire) begin
        main_d  = in_data;
        state_d = ST_FULL;
      end else if (out_fire) begin
        main_d  = FLUSH_VALUE;
        state_d = ST_EMPTY;
      end
    end
    valid_d = (state_d != ST_EMPTY);
    rdy_d   = (state_d != ST_SKIDF);
  end

  // Back-pressure counter: clear wins, otherwise saturating increment on held-but-not-taken cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (valid_q && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State, payload and counter registers; reset empties the stage and holds ready low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= FLUSH_VALUE;
      skid_q  <= FLUSH_VALUE;
      valid_q <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - randomized and directed checks of pipe_stage against a queue-level model
module tb_pipe_stage;

  localparam int         W  = 16;
  localparam logic [W-1:0] FV = 16'hDEAD;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         iv[2], ordy[2], fl[2], clr[2];
  logic         ir[2], ov[2];
  logic [W-1:0] id[2], od[2];
  logic [15:0]  sc0;
  logic [3:0]   sc1;

  int n_vec = 0;
  int n_err = 0;

  // index 0: SKID=0, CNT_W=16; index 1: SKID=1, CNT_W=4
  logic [W-1:0] mdat[2][2];
  int           mn[2];
  int           mc[2];
  bit           mrdy[2];
  int           cmax[2] = '{65535, 15};

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(W), .SKID(0), .FLUSH_VALUE(FV), .CNT_W(16)) u_comb (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .flush(fl[0]), .stall_cnt(sc0), .clr_cnt(clr[0])
  );

  pipe_stage #(.WIDTH(W), .SKID(1), .FLUSH_VALUE(FV), .CNT_W(4)) u_skid (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .flush(fl[1]), .stall_cnt(sc1), .clr_cnt(clr[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input int k, input logic v, input logic [W-1:0] d,
                        input logic r, input logic f, input logic c);
    iv[k] = v; id[k] = d; ordy[k] = r; fl[k] = f; clr[k] = c;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) set_in(k, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mc[k] = 0; mrdy[k] = 1'b0;
    end
  endtask

  function automatic bit model_rdy(input int k);
    if (k == 1) return mrdy[1];
    return (mn[0] == 0) || ordy[0];
  endfunction

  task automatic model_edge(input int k, input bit rdy);
    bit infire, outfire;
    infire  = iv[k] && rdy;
    outfire = (mn[k] > 0) && ordy[k];
    if (clr[k]) mc[k] = 0;
    else if ((mn[k] > 0) && !ordy[k] && !fl[k] && (mc[k] < cmax[k])) mc[k]++;
    if (fl[k]) begin
      mn[k] = 0;
    end else begin
      if (outfire) begin
        mdat[k][0] = mdat[k][1];
        mn[k]--;
      end
      if (infire) begin
        mdat[k][mn[k]] = id[k];
        mn[k]++;
      end
    end
    mrdy[k] = (mn[k] != 2);
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("out_valid%0d", k), ov[k], (mn[k] > 0));
      check_eq($sformatf("out_data%0d", k), od[k], (mn[k] > 0) ? mdat[k][0] : FV);
      check_eq($sformatf("stall_cnt%0d", k), (k == 0) ? 32'(sc0) : 32'(sc1), mc[k]);
    end
  endtask

  // inputs are driven just after a negedge; ready checked before the posedge, outputs after it
  task automatic cycle();
    bit rdy[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = model_rdy(k);
      check_eq($sformatf("in_ready%0d", k), ir[k], rdy[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, rdy[k]);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    idle_all();
    model_reset();
    #12;
    check_eq("rst_in_ready1", ir[1], 1'b0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // full-rate streaming through the skid stage
    for (int i = 1; i <= 10; i++) begin
      set_in(1, 1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      cycle();
    end
    set_in(1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();

    // back-pressure: A and B taken, C waits upstream, then all drain in order
    set_in(1, 1'b1, 16'h00A0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1, 1'b1, 16'h00B0, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1'b1, 16'h00C0, 1'b0, 1'b0, 1'b0); cycle();
    end
    check_eq("skidf_in_ready", ir[1], 1'b0);
    set_in(1, 1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0); cycle();
    set_in(1, 1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0); cycle();
    set_in(1, 1'b0, '0, 1'b1, 1'b0, 1'b0); cycle();
    set_in(1, 1'b0, '0, 1'b1, 1'b0, 1'b0); cycle();

    // flush from SKIDF with a concurrent input D that must vanish
    set_in(1, 1'b1, 16'h0A0A, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1, 1'b1, 16'h0B0B, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1, 1'b1, 16'h0D0D, 1'b1, 1'b1, 1'b0); cycle();
    check_eq("flush_out_valid", ov[1], 1'b0);
    check_eq("flush_out_data", od[1], FV);
    set_in(1, 1'b0, '0, 1'b1, 1'b1, 1'b0); cycle();
    set_in(1, 1'b0, '0, 1'b1, 1'b0, 1'b0); cycle();

    // asynchronous reset between edges while FULL
    set_in(1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_out_valid", ov[1], 1'b0);
    check_eq("areset_out_data", od[1], FV);
    check_eq("areset_stall_cnt", sc1, 4'd0);
    check_eq("areset_in_ready", ir[1], 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_in(1, 1'b1, 16'h5678, 1'b1, 1'b0, 1'b0); cycle();
    set_in(1, 1'b1, 16'h5678, 1'b1, 1'b0, 1'b0); cycle();
    set_in(1, 1'b0, '0, 1'b1, 1'b0, 1'b0); cycle();

    // counter saturation at 15 and clear-over-increment
    set_in(1, 1'b1, 16'h0777, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1'b0, '0, 1'b0, 1'b0, 1'b0); cycle();
    end
    check_eq("stall_saturate", sc1, 4'd15);
    set_in(1, 1'b0, '0, 1'b0, 1'b0, 1'b1); cycle();
    check_eq("stall_clear", sc1, 4'd0);
    set_in(1, 1'b0, '0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1, 1'b0, '0, 1'b1, 1'b0, 1'b0); cycle();

    // random traffic on both stages
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 2; k++) begin
        set_in(k, 1'($urandom_range(0, 1)), W'($urandom),
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 99) == 0));
      end
      cycle();
    end

    idle_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter: WIDTH, default 64, width of the payload carried through the stage (e.g. {pcplus4, instr}).
REQ-002 Parameter: SKID, default 1; 1 = two-entry skid buffer with registered in_ready, 0 = single register with combinational in_ready.
REQ-003 Parameter: FLUSH_VALUE, default all-zero WIDTH bits, payload loaded on reset and flush (NOP encoding).
REQ-004 Parameter: CNT_W, default 16, width of the stall counter.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream payload valid.
REQ-011 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-012 out_data  output  WIDTH  downstream payload, driven directly from a register.
REQ-013 flush  input  1  synchronous kill of all held entries (branch/jump squash).
REQ-014 stall_cnt  output  CNT_W  count of back-pressure cycles.
REQ-015 clr_cnt  input  1  synchronous clear of stall_cnt.

Function
REQ-016 Ordering SHALL be strict FIFO; no payload is duplicated, dropped (except by flush) or reordered.
REQ-017 Latency SHALL be exactly 1 cycle: data accepted at edge N is presented on out_data/out_valid after edge N.
REQ-018 SKID=1 states: EMPTY (no entries), FULL (main only), SKIDF (main and skid both valid).
REQ-019 EMPTY: an input transfer loads main and moves to FULL.
REQ-020 FULL: input without output loads skid and moves to SKIDF; output without input moves to EMPTY; input and output together reload main and stay in FULL.
REQ-021 SKIDF: an output transfer moves skid to main and moves to FULL; in this state in_ready=0, so no input is accepted.
REQ-022 SKID=1 in_ready SHALL be a register output equal to (state != SKIDF) and SHALL carry no combinational path from out_ready.
REQ-023 SKID=0 SHALL hold one entry, with in_ready = !out_valid || out_ready, giving full throughput with a combinational ready path.
REQ-024 out_valid SHALL be 1 exactly in FULL/SKIDF (SKID=1), or when the entry is held (SKID=0).
REQ-025 out_data SHALL equal FLUSH_VALUE whenever out_valid=0.
REQ-026 Payload SHALL be held stable while out_valid && !out_ready.
REQ-027 Flush SHALL take priority over every transfer in the same cycle: the next state is EMPTY, out_data=FLUSH_VALUE, and any input handshaken in that cycle is discarded.
REQ-028 After flush, in_ready SHALL be 1 in the following cycle.
REQ-029 A flush in EMPTY SHALL change no state.
REQ-030 stall_cnt SHALL increment by 1 in every cycle with out_valid && !out_ready && !flush, and saturate at 2^CNT_W-1 without wrapping.
REQ-031 clr_cnt SHALL take priority over increment and set stall_cnt to 0 at the next edge.

Reset
REQ-032 While reset=1, immediately and independent of clk: state=EMPTY, out_valid=0, out_data=FLUSH_VALUE, stall_cnt=0, and in_ready=0 for SKID=1.
REQ-033 At the first posedge after reset deasserts, in_ready SHALL become 1; a mid-transfer reset discards all held entries.

Verification
REQ-034 SKID=1, out_ready=1, in_valid=1 with data 1,2,3,... for 10 cycles -> out_data 1..10 on consecutive cycles one cycle later, in_ready constantly 1, stall_cnt=0.
REQ-035 SKID=1, hold out_ready=0, offer A, B, C -> A and B accepted, in_ready=0 after B, C held upstream, stall_cnt increments each cycle; release out_ready -> A, B, C delivered in order.
REQ-036 SKIDF holding A/B, assert flush with in_valid=1 data D -> next cycle out_valid=0, out_data=FLUSH_VALUE, in_ready=1, D never appears.
REQ-037 Assert async reset between clock edges while in FULL -> out_valid=0 and out_data=FLUSH_VALUE without waiting for a clock edge; first transfer after release behaves as from EMPTY.
REQ-038 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; clr_cnt together with the stall condition -> 0.
REQ-039 SKID=0, random in_valid/out_ready for 1000 cycles -> scoreboard matches in order, in_ready == !out_valid || out_ready every cycle.
